// File: rtl/stall_ctrl_pkg.sv
// Shared encodings and constants for the pipeline stall controller.
package stall_ctrl_pkg;

  // Tuse encodings: cycles until the D-stage instruction consumes an operand.
  localparam logic [1:0] TUSE_0    = 2'd0;
  localparam logic [1:0] TUSE_1    = 2'd1;
  localparam logic [1:0] TUSE_2    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Tnew encodings: cycles until a producer result can be forwarded.
  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  // Fetch restart address after reset.
  localparam logic [31:0] PC_RESET_VEC = 32'h0000_3000;

  // Multiply/divide tracker states.
  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Larger of two integers, used to size the busy counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/stall_ctrl_if.sv
// Pipeline-side hazard inputs and stall controller outputs.
interface stall_ctrl_if;
  logic [4:0]  D_rs;
  logic [4:0]  D_rt;
  logic [1:0]  D_tuse_rs;
  logic [1:0]  D_tuse_rt;
  logic        D_is_md;
  logic [4:0]  E_wa;
  logic [4:0]  M_wa;
  logic [1:0]  E_tnew;
  logic [1:0]  M_tnew;
  logic        E_start;
  logic        E_md_div;
  logic        stall;
  logic        D_en;
  logic        E_clr;
  logic        md_busy;
  logic [31:0] stall_cnt;

  // Pipeline datapath side: supplies hazard info, consumes stall controls.
  modport master (
    output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
    output E_wa, M_wa, E_tnew, M_tnew, E_start, E_md_div,
    input  stall, D_en, E_clr, md_busy, stall_cnt
  );

  // Stall controller side.
  modport slave (
    input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
    input  E_wa, M_wa, E_tnew, M_tnew, E_start, E_md_div,
    output stall, D_en, E_clr, md_busy, stall_cnt
  );
endinterface

// File: rtl/stall_ctrl_md_busy_tracker.sv
// Tracks whether the multiply/divide unit is still working on an operation.
module md_busy_tracker
  import stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic div_i,
  output logic busy_o
);

  localparam int CW = $clog2(max_int(MULT_CYCLES, DIV_CYCLES)) + 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};

  md_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // State and counter registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: load on start from idle, count down while busy, ignore restarts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          state_d = MD_BUSY;
          cnt_d   = div_i ? DIV_LOAD : MULT_LOAD;
        end else begin
          state_d = MD_IDLE;
          cnt_d   = CNT_ZERO;
        end
      end
      MD_BUSY: begin
        if (cnt_q == CNT_ONE) begin
          state_d = MD_IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = MD_BUSY;
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Busy flag decoded straight from the state flop.
  always_comb begin
    busy_o = 1'b0;
    if (state_q == MD_BUSY) begin
      busy_o = 1'b1;
    end else begin
      busy_o = 1'b0;
    end
  end

endmodule

// File: rtl/stall_ctrl.sv
// Hazard detection and stall generation for the D stage, plus stall statistics.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  stall_ctrl_if.slave bus
);

  logic        hazard_e;
  logic        hazard_m;
  logic        hazard_md;
  logic        stall_s;
  logic        md_busy_s;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // A producer blocks a source only if it writes a real register that the
  // consumer needs before the result becomes forwardable.
  function automatic logic src_hit(input logic [4:0] wa, input logic [1:0] tnew,
                                   input logic [4:0] src, input logic [1:0] tuse);
    return (wa != 5'd0) && (wa == src) && (tnew > tuse);
  endfunction

  md_busy_tracker #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy (
    .clk     (clk),
    .reset   (reset),
    .start_i (bus.E_start),
    .div_i   (bus.E_md_div),
    .busy_o  (md_busy_s)
  );

  // Combine all hazard sources into one same-cycle stall request.
  always_comb begin
    hazard_e  = src_hit(bus.E_wa, bus.E_tnew, bus.D_rs, bus.D_tuse_rs) |
                src_hit(bus.E_wa, bus.E_tnew, bus.D_rt, bus.D_tuse_rt);
    hazard_m  = src_hit(bus.M_wa, bus.M_tnew, bus.D_rs, bus.D_tuse_rs) |
                src_hit(bus.M_wa, bus.M_tnew, bus.D_rt, bus.D_tuse_rt);
    hazard_md = bus.D_is_md & (md_busy_s | bus.E_start);
    stall_s   = hazard_e | hazard_m | hazard_md;
  end

  // Saturating count of stalled cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Drive pipeline controls: hold PC and F/D, bubble into D/E.
  always_comb begin
    bus.stall     = stall_s;
    bus.D_en      = ~stall_s;
    bus.E_clr     = stall_s;
    bus.md_busy   = md_busy_s;
    bus.stall_cnt = stall_cnt_q;
  end

endmodule
